// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants for the mux scan controller and its bench.
//   NumChan       : number of mux channels scanned
//   ChanW         : width of a channel index
//   SettleDefault : default hold time per channel, in clock cycles
//   state_e       : controller FSM state encoding
package mux_scan_ctrl_pkg;

  localparam int unsigned NumChan       = 16;
  localparam int unsigned ChanW         = 4;
  localparam int unsigned SettleDefault = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_16to1.sv
// Plain 16-to-1 multiplexer, the device scanned by mux_scan_ctrl.
//   d : the 16 data inputs
//   s : select
//   f : selected data bit
module mux_16to1 (
  input  logic [15:0] d,
  input  logic [3:0]  s,
  output logic        f
);

  assign f = d[s];

endmodule

// File: rtl/mux_next_chan.sv
// Combinational search for the next enabled channel.
//   mask  : channel enable bits
//   cur   : current channel index
//   first : 1 = search from channel 0 inclusive, 0 = search strictly above cur
//   nxt   : lowest qualifying enabled channel (cur when none found)
//   found : a qualifying channel exists
module mux_next_chan
  import mux_scan_ctrl_pkg::*;
(
  input  logic [NumChan-1:0] mask,
  input  logic [ChanW-1:0]   cur,
  input  logic               first,
  output logic [ChanW-1:0]   nxt,
  output logic               found
);

  always_comb begin
    found = 1'b0;
    nxt   = cur;
    // Walk downward so the lowest qualifying index is the last one written.
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        found = 1'b1;
        nxt   = ChanW'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an external 16-to-1 mux in ascending order,
// holding each select value for SETTLE cycles and sampling the mux output on
// the last of them.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : scan request, only honoured in idle
//   chan_mask : channel enables, captured when start is accepted
//   mux_out   : output of the scanned mux
//   sel       : registered mux select
//   busy      : scan in progress
//   done      : one-cycle completion pulse
//   data      : scan result, bit i = sample of channel i
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = SettleDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NumChan-1:0] chan_mask,
  input  logic               mux_out,
  output logic [ChanW-1:0]   sel,
  output logic               busy,
  output logic               done,
  output logic [NumChan-1:0] data
);

  localparam logic [7:0] CntLoad = 8'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [ChanW-1:0]   sel_q, sel_d;
  logic [NumChan-1:0] data_q, data_d;
  logic [NumChan-1:0] mask_q, mask_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               search_first;
  logic [NumChan-1:0] search_mask;
  logic [ChanW-1:0]   nxt_chan;
  logic               nxt_found;

  // In idle the search looks for the lowest channel of the incoming mask;
  // during a scan it looks above the current select in the latched mask.
  assign search_first = (state_q == StIdle);
  assign search_mask  = search_first ? chan_mask : mask_q;

  mux_next_chan u_next_chan (
    .mask  (search_mask),
    .cur   (sel_q),
    .first (search_first),
    .nxt   (nxt_chan),
    .found (nxt_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d = '0;
          mask_d = chan_mask;
          if (chan_mask != '0) begin
            sel_d   = nxt_chan;
            cnt_d   = CntLoad;
            state_d = StSettle;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          data_d[sel_q] = mux_out;
          if (nxt_found) begin
            sel_d = nxt_chan;
            cnt_d = CntLoad;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel  = sel_q;
  assign data = data_q;
  assign busy = (state_q == StSettle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a real mux_16to1. Expected scan results
// are queued when a start is issued and retired when done is seen.
module tb_mux_scan_ctrl;
  import mux_scan_ctrl_pkg::*;

  localparam int SetC = int'(SettleDefault);

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] chan_mask;
  logic [15:0] in_bits;
  logic        mux_out;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] data;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #25 clk = ~clk;

  mux_scan_ctrl #(
    .SETTLE (SettleDefault)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .chan_mask (chan_mask),
    .mux_out   (mux_out),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .data      (data)
  );

  mux_16to1 u_mux (
    .d (in_bits),
    .s (sel),
    .f (mux_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one scan and follow it cycle by cycle. With disturb set, start is
  // pulsed again mid-scan with a different mask.
  task automatic run_scan(input logic [15:0] m, input logic [15:0] iv, input bit disturb);
    int   chans[$];
    int   n;
    int   lat;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
    n   = chans.size();
    lat = n * SetC + 1;
    in_bits   = iv;
    chan_mask = m;
    start     = 1'b1;
    sb.push_back('{data: m & iv, lat: lat});
    step();
    start     = 1'b0;
    chan_mask = ~m;
    seen      = 1'b0;
    for (int c = 1; c <= lat + 2 && !seen; c++) begin
      check("busy", 32'(busy), 32'(c <= n * SetC));
      if (c <= n * SetC) check("sel", 32'(sel), chans[(c - 1) / SetC]);
      if (done) begin
        seen = 1'b1;
        e    = sb.pop_front();
        check("latency", c, e.lat);
        check("data", 32'(data), 32'(e.data));
      end
      if (disturb && c == 5) begin
        start     = 1'b1;
        chan_mask = 16'h00F0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int done_cnt;
    rst       = 1'b1;
    start     = 1'b0;
    chan_mask = 16'h0;
    in_bits   = 16'h0;
    step();
    step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Full scan of a patterned input.
    run_scan(16'hFFFF, 16'b1010101101011100, 1'b0);

    // Sparse mask: only channels 0 and 15.
    run_scan(16'h8001, 16'h8001, 1'b0);
    in_bits = 16'h0001;
    repeat (3) step();
    check("hold_data", 32'(data), 32'h8001);
    check("hold_sel", 32'(sel), 32'd15);

    // Empty mask finishes immediately with cleared data.
    run_scan(16'h0000, 16'hFFFF, 1'b0);
    check("hold_sel_empty", 32'(sel), 32'd15);

    // Second start mid-scan is ignored.
    run_scan(16'hFFFF, 16'h3C5A, 1'b1);

    // Disabled channels read zero even when the input is high.
    run_scan(16'h0F0F, 16'hFFFF, 1'b0);

    // Reset mid-scan aborts without done.
    in_bits   = 16'hFFFF;
    chan_mask = 16'hFFFF;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    done_cnt = 0;
    repeat (70) begin
      step();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // A fresh scan completes normally after the abort.
    run_scan(16'hFFFF, 16'h5AA5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4: clock cycles each select value is held before sampling (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 The block SHALL have port chan_mask, input, 16, channel enables, latched when start is accepted.
REQ-006 The block SHALL have port mux_out, input, 1, the output f of the 16-to-1 mux being scanned.
REQ-007 The block SHALL have port sel, output, 4, the registered select driven to the mux S input.
REQ-008 The block SHALL have port busy, output, 1, high while a scan is in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse at scan completion.
REQ-010 The block SHALL have port data, output, 16, the scan result; bit i holds the value sampled on channel i.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SETTLE and DONE.
REQ-012 In IDLE with start=1 and a nonzero chan_mask, the block SHALL latch chan_mask, clear data to 0, load sel with the lowest enabled channel, load the settle counter with SETTLE-1, and enter SETTLE.
REQ-013 In IDLE with start=1 and chan_mask=0, the block SHALL clear data and enter DONE directly, leaving sel unchanged.
REQ-014 In SETTLE, sel SHALL stay constant for exactly SETTLE cycles per enabled channel, with the counter decrementing each cycle.
REQ-015 On the SETTLE cycle where the counter is 0, the block SHALL write mux_out into data[sel].
REQ-016 On that same cycle, it SHALL advance sel to the next higher enabled channel and reload the counter, or enter DONE if no higher enabled channel exists.
REQ-017 Channels SHALL be scanned in ascending index order, and masked channels SHALL take zero cycles.
REQ-018 No wrap-around SHALL occur: the scan ends after the highest enabled channel.
REQ-019 Disabled channels' data bits SHALL read 0.
REQ-020 busy SHALL be 1 exactly while in SETTLE.
REQ-021 done SHALL be 1 exactly for the single cycle in DONE, after which the FSM returns to IDLE.
REQ-022 start SHALL be ignored in SETTLE and DONE, and chan_mask changes after acceptance SHALL have no effect.
REQ-023 Latency from the start edge to done high SHALL be N*SETTLE+1 cycles for N enabled channels, and 1 cycle for N=0.
REQ-024 data and sel SHALL hold their values in IDLE until the next accepted start.
REQ-025 A start arriving on the DONE cycle SHALL be ignored; the earliest restart is the following IDLE cycle.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with sel=0, data=0, busy=0, done=0, latched mask=0 and counter=0.
REQ-027 Reset SHALL take priority over start and over any in-progress scan; a reset mid-scan SHALL abort the scan without asserting done.

Structure
REQ-028 FSM state encodings and the default SETTLE value SHALL live in a shared constants include file used by this block and its testbench.
REQ-029 The next-enabled-channel search (16-bit mask, current index -> next index plus found flag) SHALL be one combinational sub-module named mux_next_chan.
REQ-030 The bench SHALL instantiate mux_scan_ctrl driving a real mux_16to1, connecting sel to S and mux_out to f.
REQ-031 The clock period SHALL exceed the mux's 30 ns worst-case delay so that SETTLE=1 is valid; the bench SHALL use a 50 ns period.

Verification
REQ-032 Full scan: I=16'b1010101101011100, mask=16'hFFFF, SETTLE=4 -> busy for 64 cycles, done at cycle 65, data=16'b1010101101011100.
REQ-033 Sparse mask: mask=16'h8001, I=16'h8001 -> sel visits 0 then 15 only, done at cycle 9, data=16'h8001.
REQ-034 Empty mask: start with mask=0 -> done one cycle later, busy never high, data=0.
REQ-035 Start ignored: start pulsed again mid-scan with a different mask -> scan, timing and data unchanged.
REQ-036 Reset mid-scan: rst at cycle 10 of a full scan -> next cycle sel=0, data=0, busy=0, done never asserted; a new start then completes normally.
REQ-037 Input change after sampling: I bit 15 changes after channel 15 is sampled -> data keeps the sampled value until the next start.
